// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receiver-side checker for a registered hsync/vsync/de video stream.
//   Recovers the pixel coordinate of each active pixel, measures line and
//   frame geometry, compares it with the expected timing and reports lock
//   plus sticky error bits.
//
// Ports
//   clk         pixel clock, all inputs synchronous to it
//   reset       asynchronous, active-high reset
//   hsync       horizontal sync (assert level SYNC_POL)
//   vsync       vertical sync (assert level SYNC_POL)
//   de          data enable
//   err_clr     clears the sticky error bits
//   rx, ry      recovered pixel coordinate, aligned with rde
//   rde         de delayed one cycle
//   locked      geometry matched for LOCK_FRAMES consecutive frames
//   h_period    last measured line length in clocks
//   v_period    last measured frame length in lines
//   frame_count vsync assert edges seen, wraps
//   err         sticky: [0] line length, [1] active pixels,
//               [2] frame length, [3] active lines
//
// state  | meaning
// SEARCH | waiting for the first vsync edge, geometry not checked
// TRACK  | checking frames, counting consecutive good ones
// LOCKED | LOCK_FRAMES good frames seen, any error drops back to TRACK
module vga_sync_decoder #(
  parameter int   CORDW       = 10,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   H_TOTAL     = 800,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  input  logic               err_clr,
  output logic [CORDW-1:0]   rx,
  output logic [CORDW-1:0]   ry,
  output logic               rde,
  output logic               locked,
  output logic [CORDW+1:0]   h_period,
  output logic [CORDW+1:0]   v_period,
  output logic [15:0]        frame_count,
  output logic [3:0]         err
);

  localparam int CW = CORDW + 2;
  localparam logic [CW-1:0] CMAX       = '1;
  localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
  localparam logic [3:0]    LOCK_C     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + CW'(1);
  endfunction

  state_t            state_q, state_d;
  logic              hs_q, vs_q, de_q;
  logic [CW-1:0]     hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [CW-1:0]     lcnt_q, lcnt_d, acnt_q, acnt_d;
  logic              h_seen_q, h_seen_d, frame_bad_q, frame_bad_d;
  logic [3:0]        good_q, good_d;
  logic [CORDW-1:0]  rx_q, ry_q;
  logic              rde_q, locked_q;
  logic [CW-1:0]     h_period_q, h_period_d, v_period_q, v_period_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [3:0]        err_q, err_d;

  logic          h_edge, v_edge, de_fall, checking;
  logic          h_err, p_err, v_err, a_err, frame_fail;
  logic [CW-1:0] h_len, lcnt_eff, acnt_eff;
  logic [3:0]    good_inc;

  always_comb begin
    h_edge   = (hsync == SYNC_POL) && (hs_q != SYNC_POL);
    v_edge   = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    de_fall  = de_q && !de;
    checking = (state_q != SEARCH);

    h_len    = sat_inc(hcnt_q);
    // A line edge coinciding with the frame edge belongs to the ending frame,
    // likewise a de fall on the frame edge cycle.
    lcnt_eff = h_edge  ? sat_inc(lcnt_q) : lcnt_q;
    acnt_eff = de_fall ? sat_inc(acnt_q) : acnt_q;

    h_err = h_edge && h_seen_q && checking && (h_len != H_TOTAL_C);
    p_err = de_fall && checking && (pcnt_q != H_ACTIVE_C);
    v_err = v_edge && checking && (lcnt_eff != V_TOTAL_C);
    a_err = v_edge && checking && (acnt_eff != V_ACTIVE_C);
    frame_fail = frame_bad_q | h_err | p_err | v_err | a_err;

    hcnt_d        = h_edge ? '0 : sat_inc(hcnt_q);
    h_period_d    = h_edge ? h_len : h_period_q;
    // The first line edge after SEARCH has no reference point, so skip it.
    h_seen_d      = (state_q == SEARCH) ? 1'b0 : (h_seen_q | h_edge);
    pcnt_d        = de_fall ? '0 : (de ? sat_inc(pcnt_q) : pcnt_q);
    acnt_d        = v_edge ? '0 : acnt_eff;
    lcnt_d        = v_edge ? '0 : lcnt_eff;
    v_period_d    = v_edge ? lcnt_eff : v_period_q;
    frame_count_d = frame_count_q + 16'(v_edge);
    frame_bad_d   = v_edge ? 1'b0 : (frame_bad_q | h_err | p_err);
    // Set beats clear when both happen in the same cycle.
    err_d         = (err_clr ? 4'b0 : err_q) | {a_err, v_err, p_err, h_err};

    good_inc = good_q + 4'd1;
    state_d  = state_q;
    good_d   = good_q;
    case (state_q)
      SEARCH: begin
        if (v_edge) begin
          state_d = TRACK;
          good_d  = 4'd0;
        end
      end
      TRACK: begin
        if (v_edge) begin
          if (frame_fail) begin
            good_d = 4'd0;
          end else if (good_inc >= LOCK_C) begin
            state_d = LOCKED;
            good_d  = 4'd0;
          end else begin
            good_d = good_inc;
          end
        end
      end
      LOCKED: begin
        if (h_err || p_err || (v_edge && frame_fail)) begin
          state_d = TRACK;
          good_d  = 4'd0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      hcnt_q        <= '0;
      pcnt_q        <= '0;
      lcnt_q        <= '0;
      acnt_q        <= '0;
      h_seen_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      good_q        <= 4'd0;
      rx_q          <= '0;
      ry_q          <= '0;
      rde_q         <= 1'b0;
      locked_q      <= 1'b0;
      h_period_q    <= '0;
      v_period_q    <= '0;
      frame_count_q <= '0;
      err_q         <= 4'd0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hsync;
      vs_q          <= vsync;
      de_q          <= de;
      hcnt_q        <= hcnt_d;
      pcnt_q        <= pcnt_d;
      lcnt_q        <= lcnt_d;
      acnt_q        <= acnt_d;
      h_seen_q      <= h_seen_d;
      frame_bad_q   <= frame_bad_d;
      good_q        <= good_d;
      rx_q          <= pcnt_q[CORDW-1:0];
      ry_q          <= acnt_q[CORDW-1:0];
      rde_q         <= de;
      locked_q      <= (state_d == LOCKED);
      h_period_q    <= h_period_d;
      v_period_q    <= v_period_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  assign rx          = rx_q;
  assign ry          = ry_q;
  assign rde         = rde_q;
  assign locked      = locked_q;
  assign h_period    = h_period_q;
  assign v_period    = v_period_q;
  assign frame_count = frame_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster:
// 8 active of 12 clocks per line, 6 active of 9 lines per frame.
// Line layout: hsync low at c=0..1, de at c=2..9.
// Frame layout: vsync low on lines 0..1, active lines 2..7, line 8 blank.
module tb_vga_sync_decoder;

  localparam int CORDW = 6;
  localparam int CW    = CORDW + 2;

  logic             clk, reset, hsync, vsync, de, err_clr;
  logic [CORDW-1:0] rx, ry;
  logic             rde, locked;
  logic [CW-1:0]    h_period, v_period;
  logic [15:0]      frame_count;
  logic [3:0]       err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] s0_locked, s0_hp, s0_vp, s0_fc, s0_err;
  logic [31:0] p_rx, p_ry, p_rde, p_locked, p_err, p_hp;
  logic        rst_any;

  vga_sync_decoder #(
    .CORDW(CORDW), .H_ACTIVE(8), .V_ACTIVE(6), .H_TOTAL(12), .V_TOTAL(9),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
    .err_clr(err_clr), .rx(rx), .ry(ry), .rde(rde), .locked(locked),
    .h_period(h_period), .v_period(v_period), .frame_count(frame_count),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame. Index arguments of -1 disable the feature.
  // short_l: that line is 11 clocks; long_l: de held 9 cycles on that line;
  // clr_l/clr_c: err_clr pulse; rst_l: reset at c=5..7 of that line;
  // pl/pc: probe point, sampled just after the edge that latched it.
  task automatic run_frame(input int nlines, input int short_l, input int long_l,
                           input int clr_l, input int clr_c, input int rst_l,
                           input int pl, input int pc);
    for (int l = 0; l < nlines; l++) begin
      int len;
      int dl;
      len = (l == short_l) ? 11 : 12;
      dl  = (l == long_l) ? 9 : 8;
      for (int c = 0; c < len; c++) begin
        hsync   = (c >= 2);
        vsync   = (l >= 2);
        de      = (l >= 2) && (l < 8) && (c >= 2) && (c < 2 + dl);
        err_clr = (l == clr_l) && (c == clr_c);
        reset   = (l == rst_l) && (c >= 5) && (c < 8);
        if (l == rst_l && c == 5) begin
          #1;
          rst_any = |{rx, ry, rde, locked, h_period, v_period, frame_count, err};
        end
        step();
        if (l == 0 && c == 0) begin
          s0_locked = 32'(locked);
          s0_hp     = 32'(h_period);
          s0_vp     = 32'(v_period);
          s0_fc     = 32'(frame_count);
          s0_err    = 32'(err);
        end
        if (l == pl && c == pc) begin
          p_rx     = 32'(rx);
          p_ry     = 32'(ry);
          p_rde    = 32'(rde);
          p_locked = 32'(locked);
          p_err    = 32'(err);
          p_hp     = 32'(h_period);
        end
      end
    end
    err_clr = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    de      = 1'b0;
    err_clr = 1'b0;
    #1 reset = 1'b1;
    repeat (3) step();
    chk("rst_any", 32'(|{rx, ry, rde, locked, h_period, v_period, frame_count, err}), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    repeat (2) step();

    // A, B, C: lock one cycle after the third vsync edge
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("B_end_locked", 32'(locked), 0);
    run_frame(9, -1, -1, -1, -1, -1, 7, 9);
    chk("C_locked", s0_locked, 1);
    chk("C_hper", s0_hp, 12);
    chk("C_vper", s0_vp, 9);
    chk("C_err", s0_err, 0);
    chk("C_fcount", s0_fc, 3);
    chk("C_last_rx", p_rx, 7);
    chk("C_last_ry", p_ry, 5);
    chk("C_last_rde", p_rde, 1);

    // D: first pixel of a new frame
    run_frame(9, -1, -1, -1, -1, -1, 2, 2);
    chk("D_locked", s0_locked, 1);
    chk("D_fcount", s0_fc, 4);
    chk("D_first_rx", p_rx, 0);
    chk("D_first_ry", p_ry, 0);
    chk("D_first_rde", p_rde, 1);

    // E: line 4 is one clock short
    run_frame(9, 4, -1, -1, -1, -1, 5, 0);
    chk("E_short_err", p_err, 1);
    chk("E_short_hper", p_hp, 11);
    chk("E_short_locked", p_locked, 0);

    // F, G good; relock at H start; err_clr during H
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("F_locked", s0_locked, 0);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("G_end_locked", 32'(locked), 0);
    run_frame(9, -1, -1, 1, 5, -1, 1, 5);
    chk("H_relocked", s0_locked, 1);
    chk("H_err_sticky", s0_err, 1);
    chk("H_clr_err", p_err, 0);
    chk("H_clr_locked", p_locked, 1);

    // I: de held 9 cycles on line 3
    run_frame(9, -1, 3, -1, -1, -1, 3, 11);
    chk("I_long_err", p_err, 2);
    chk("I_long_locked", p_locked, 0);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("J_err", s0_err, 2);
    chk("J_vper", s0_vp, 9);
    chk("J_locked", s0_locked, 0);

    // K good, lock at L start; L drops a line
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    run_frame(8, -1, -1, -1, -1, -1, -1, -1);
    chk("L_locked", s0_locked, 1);
    chk("L_end_locked", 32'(locked), 1);

    // M: frame-length error from L, then short line with coincident err_clr
    run_frame(9, 4, -1, 5, 0, -1, 5, 0);
    chk("M_err", s0_err, 6);
    chk("M_vper", s0_vp, 8);
    chk("M_locked", s0_locked, 0);
    chk("M_clr_set_wins", p_err, 1);
    chk("M_short_hper", p_hp, 11);

    // N: reset mid-frame; O, P, Q reacquire
    run_frame(9, -1, -1, -1, -1, 4, -1, -1);
    chk("N_rst_async", 32'(rst_any), 0);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("O_err", s0_err, 0);
    chk("O_locked", s0_locked, 0);
    chk("O_fcount", s0_fc, 1);
    chk("O_vper_partial", s0_vp, 5);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("P_end_locked", 32'(locked), 0);
    run_frame(9, -1, -1, -1, -1, -1, -1, -1);
    chk("Q_locked", s0_locked, 1);
    chk("Q_err", s0_err, 0);
    chk("Q_fcount", s0_fc, 3);
    chk("Q_hper", s0_hp, 12);
    chk("Q_vper", s0_vp, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
